wb_mem_slave: RTL and testbench



---
 rtl/ecap5_dproc_pkg.sv | 24 ++
 rtl/wb_req_fifo.sv | 71 +++++++
 rtl/wb_mem_slave.sv | 150 +++++++++++++++
 tb/tb_wb_mem_slave.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ecap5_dproc_pkg.sv
// Shared types for the data-processor memory path.
//   wb_req_t      : one captured Wishbone request {adr, dat, we, sel}
//   exec_state_t  : execution FSM states of wb_mem_slave
//   WB_SEL_WIDTH  : number of byte lanes on the 32-bit Wishbone bus
package ecap5_dproc_pkg;

    localparam int WB_SEL_WIDTH = 4;

    typedef struct packed {
        logic [31:0]             adr;
        logic [31:0]             dat;
        logic                    we;
        logic [WB_SEL_WIDTH-1:0] sel;
    } wb_req_t;

    // S_IDLE: queue empty; S_WAIT: head present, wait counter > 0;
    // S_EXEC: head present, counter == 0, head executes at the next edge.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_EXEC = 2'd2
    } exec_state_t;

endpackage

// File: rtl/wb_req_fifo.sv
// In-order request queue for wb_mem_slave.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   push, din  : enqueue din at the tail (ignored when full)
//   pop        : drop the head entry (ignored when empty)
//   flush      : discard every entry; wins over push/pop
//   head       : entry at the head of the queue
//   full/empty : occupancy flags, derived from the count register only
//   count      : number of stored entries
module wb_req_fifo
    import ecap5_dproc_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  wb_req_t          din,
    output wb_req_t          head,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int              PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

    wb_req_t          mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    // Explicit wrap so pointers stay modulo DEPTH even when DEPTH == 1.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST) ? '0 : p + PTR_W'(1);
    endfunction

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign head    = mem[rd_ptr];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage is not reset; only the pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (!rst && !flush && do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/wb_mem_slave.sv
// Pipelined Wishbone B4 responder backed by a word-addressed RAM with
// byte-lane writes and programmable wait states.
// Ports:
//   clk_i, rst_i          : clock, synchronous active-high reset
//   wb_adr_i              : byte address, word index = adr[ADDR_WIDTH+1:2]
//   wb_dat_i, wb_we_i     : write data, 1 = write
//   wb_sel_i              : byte lane enables
//   wb_stb_i, wb_cyc_i    : strobe, cycle valid
//   wb_dat_o, wb_ack_o    : read data (0 unless acking a read), one-cycle ack
//   wb_stall_o            : request not accepted this cycle
//
// Handshake: a request transfers at a rising edge when
// wb_cyc_i & wb_stb_i & ~wb_stall_o. wb_stall_o is the registered queue-full
// flag, so it never depends on this cycle's inputs. Each accepted request
// gets exactly one wb_ack_o pulse, in order. Dropping wb_cyc_i aborts
// everything pending: queue flushed, head not executed, no ack.
module wb_mem_slave
    import ecap5_dproc_pkg::*;
#(
    parameter int ADDR_WIDTH  = 10,
    parameter int LATENCY     = 0,
    parameter int QUEUE_DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_we_i,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_stb_i,
    input  logic        wb_cyc_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_stall_o
);

    localparam int         CNT_W = $clog2(QUEUE_DEPTH) + 1;
    localparam int         WORDS = 1 << ADDR_WIDTH;
    localparam logic [3:0] LAT   = 4'(LATENCY);

    logic [31:0] ram [WORDS];

    wb_req_t               req_in;
    wb_req_t               head;
    logic                  push;
    logic                  pop;
    logic                  flush;
    logic                  full;
    logic                  empty;
    logic [CNT_W-1:0]      count;
    logic [ADDR_WIDTH-1:0] head_idx;

    exec_state_t state;
    exec_state_t state_d;
    logic [3:0]  wait_cnt;
    logic [3:0]  wait_cnt_d;
    logic        ack_q;
    logic [31:0] dat_q;

    // Address bits outside the word index are ignored (aliasing).
    logic unused_bits;
    assign unused_bits = ^{head.adr[31:ADDR_WIDTH+2], head.adr[1:0], empty};

    assign req_in   = '{adr: wb_adr_i, dat: wb_dat_i, we: wb_we_i, sel: wb_sel_i};
    assign flush    = ~wb_cyc_i;
    assign push     = wb_cyc_i & wb_stb_i & ~full;
    assign pop      = wb_cyc_i & (state == S_EXEC);
    assign head_idx = head.adr[ADDR_WIDTH+1:2];

    wb_req_fifo #(
        .DEPTH (QUEUE_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk   (clk_i),
        .rst   (rst_i),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .din   (req_in),
        .head  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
            ack_q    <= 1'b0;
            dat_q    <= '0;
        end else begin
            state    <= state_d;
            wait_cnt <= wait_cnt_d;
            ack_q    <= pop;
            dat_q    <= (pop && !head.we) ? ram[head_idx] : '0;
        end
    end

    // A new head (first push into an empty queue, or the entry behind a
    // popped head) reloads the counter on the same edge, so LATENCY = 0
    // sustains one ack per cycle.
    always_comb begin
        state_d    = state;
        wait_cnt_d = wait_cnt;
        case (state)
            S_IDLE: begin
                if (push) begin
                    wait_cnt_d = LAT;
                    state_d    = (LAT == 4'd0) ? S_EXEC : S_WAIT;
                end
            end
            S_WAIT: begin
                wait_cnt_d = wait_cnt - 4'd1;
                if (wait_cnt == 4'd1) state_d = S_EXEC;
            end
            S_EXEC: begin
                if ((count > CNT_W'(1)) || push) begin
                    wait_cnt_d = LAT;
                    state_d    = (LAT == 4'd0) ? S_EXEC : S_WAIT;
                end else begin
                    wait_cnt_d = '0;
                    state_d    = S_IDLE;
                end
            end
            default: begin
                wait_cnt_d = '0;
                state_d    = S_IDLE;
            end
        endcase
        if (flush) begin
            wait_cnt_d = '0;
            state_d    = S_IDLE;
        end
    end

    // RAM is never reset; a write happens only when the head really executes.
    always_ff @(posedge clk_i) begin
        if (!rst_i && pop && head.we) begin
            for (int b = 0; b < WB_SEL_WIDTH; b++) begin
                if (head.sel[b]) ram[head_idx][8*b +: 8] <= head.dat[8*b +: 8];
            end
        end
    end

    assign wb_ack_o   = ack_q;
    assign wb_dat_o   = dat_q;
    assign wb_stall_o = full;

endmodule

// File: tb/tb_wb_mem_slave.sv
module tb_wb_mem_slave;
    import ecap5_dproc_pkg::*;

    localparam int QD   = 2;
    localparam int LAT0 = 0;
    localparam int LAT1 = 3;

    // ---------------- clock / DUTs ----------------
    logic        clk = 1'b0;
    logic        rst, cyc, stb, we;
    logic [31:0] adr, wdat;
    logic [3:0]  sel;
    logic [31:0] dat_o0, dat_o1;
    logic        ack_o0, ack_o1, stall_o0, stall_o1;

    always #5 clk = ~clk;

    wb_mem_slave #(.ADDR_WIDTH(10), .LATENCY(LAT0), .QUEUE_DEPTH(QD)) dut0 (
        .clk_i(clk), .rst_i(rst), .wb_adr_i(adr), .wb_dat_i(wdat), .wb_we_i(we),
        .wb_sel_i(sel), .wb_stb_i(stb), .wb_cyc_i(cyc),
        .wb_dat_o(dat_o0), .wb_ack_o(ack_o0), .wb_stall_o(stall_o0)
    );

    wb_mem_slave #(.ADDR_WIDTH(10), .LATENCY(LAT1), .QUEUE_DEPTH(QD)) dut3 (
        .clk_i(clk), .rst_i(rst), .wb_adr_i(adr), .wb_dat_i(wdat), .wb_we_i(we),
        .wb_sel_i(sel), .wb_stb_i(stb), .wb_cyc_i(cyc),
        .wb_dat_o(dat_o1), .wb_ack_o(ack_o1), .wb_stall_o(stall_o1)
    );

    int total = 0;
    int bad = 0;
    int cycle_n = 0;

    // ---------------- reference model ----------------
    // Each request records the cycle it reached the head; it completes at the
    // edge closing cycle head_start + latency. Memory is a plain word array.
    wb_req_t     q0[$];
    wb_req_t     q1[$];
    int          head_start [2];
    int          m_acc [2];
    logic        m_ack [2];
    logic [31:0] m_dat [2];
    logic        m_known [2];
    logic [31:0] m_mem [2][1024];
    logic        m_valid [2][1024];

    logic [31:0] ack_log0[$];
    logic [31:0] ack_log1[$];
    int          ack_cyc0[$];
    int          ack_cyc1[$];
    logic        stall_seen0, stall_seen1;

    function automatic int q_size(int m);
        return (m == 0) ? q0.size() : q1.size();
    endfunction

    task automatic q_push(int m, wb_req_t r);
        if (m == 0) q0.push_back(r); else q1.push_back(r);
    endtask

    task automatic q_pop(int m, output wb_req_t r);
        if (m == 0) r = q0.pop_front(); else r = q1.pop_front();
    endtask

    task automatic q_clear(int m);
        if (m == 0) q0.delete(); else q1.delete();
    endtask

    task automatic model_edge(int m);
        int      lat;
        bit      was_full;
        wb_req_t r;
        int      idx;
        lat = (m == 0) ? LAT0 : LAT1;
        m_ack[m]   = 1'b0;
        m_dat[m]   = '0;
        m_known[m] = 1'b1;
        if (rst || !cyc) begin
            q_clear(m);
            return;
        end
        was_full = (q_size(m) == QD);
        if (q_size(m) > 0 && cycle_n >= head_start[m] + lat) begin
            q_pop(m, r);
            idx = int'(r.adr[11:2]);
            m_ack[m] = 1'b1;
            if (r.we) begin
                for (int b = 0; b < 4; b++)
                    if (r.sel[b]) m_mem[m][idx][8*b +: 8] = r.dat[8*b +: 8];
                if (r.sel == 4'hF) m_valid[m][idx] = 1'b1;
            end else begin
                m_dat[m]   = m_mem[m][idx];
                m_known[m] = m_valid[m][idx];
            end
            head_start[m] = cycle_n + 1;
        end
        if (stb && !was_full) begin
            if (q_size(m) == 0) head_start[m] = cycle_n + 1;
            r.adr = adr; r.dat = wdat; r.we = we; r.sel = sel;
            q_push(m, r);
            m_acc[m]++;
        end
    endtask

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle_n);
        end
    endtask

    task automatic tick();
        model_edge(0);
        model_edge(1);
        @(posedge clk);
        #1;
        cycle_n++;
        if (ack_o0) begin ack_log0.push_back(dat_o0); ack_cyc0.push_back(cycle_n); end
        if (ack_o1) begin ack_log1.push_back(dat_o1); ack_cyc1.push_back(cycle_n); end
        stall_seen0 |= stall_o0;
        stall_seen1 |= stall_o1;
        check("ack0", 32'(ack_o0), 32'(m_ack[0]));
        check("ack1", 32'(ack_o1), 32'(m_ack[1]));
        check("stall0", 32'(stall_o0), 32'(q_size(0) == QD));
        check("stall1", 32'(stall_o1), 32'(q_size(1) == QD));
        if (m_known[0]) check("dat0", dat_o0, m_dat[0]);
        if (m_known[1]) check("dat1", dat_o1, m_dat[1]);
    endtask

    task automatic clear_logs();
        ack_log0.delete(); ack_log1.delete();
        ack_cyc0.delete(); ack_cyc1.delete();
        stall_seen0 = 1'b0;
        stall_seen1 = 1'b0;
    endtask

    // ---------------- driver tasks ----------------
    task automatic present(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
        tick();
    endtask

    task automatic drain();
        int n;
        n = 0;
        cyc = 1'b1;
        stb = 1'b0;
        while ((q_size(0) + q_size(1) != 0 || ack_o0 || ack_o1) && n < 80) begin
            tick();
            n++;
        end
        if (q_size(0) + q_size(1) != 0 || ack_o0 || ack_o1) begin
            total++; bad++;
            $display("FAIL drain: still busy after %0d cycles", n);
        end
    endtask

    task automatic do_op(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, output logic [31:0] rd0,
                         output logic [31:0] rd1, output int lat0, output int lat1);
        bit got0, got1;
        got0 = 0; got1 = 0; rd0 = '0; rd1 = '0; lat0 = -1; lat1 = -1;
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
        for (int n = 1; n <= 30; n++) begin
            tick();
            stb = 1'b0;
            if (ack_o0 && !got0) begin got0 = 1; rd0 = dat_o0; lat0 = n; end
            if (ack_o1 && !got1) begin got1 = 1; rd1 = dat_o1; lat1 = n; end
            if (got0 && got1) break;
        end
        check("op_done", {30'd0, got0, got1}, 32'h3);
    endtask

    task automatic check_ack(input string name, input int which, input int i,
                             input logic [31:0] exp_d, input int exp_c);
        int sz;
        sz = (which == 0) ? ack_log0.size() : ack_log1.size();
        if (i < sz) begin
            check({name, "_dat"}, (which == 0) ? ack_log0[i] : ack_log1[i], exp_d);
            check({name, "_cyc"}, (which == 0) ? ack_cyc0[i] : ack_cyc1[i], exp_c);
        end else begin
            total++; bad++;
            $display("FAIL %s: ack %0d missing, got %0d acks", name, i, sz);
        end
    endtask

    // ---------------- test ----------------
    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
        logic [31:0] exp;
    } vec_t;

    vec_t        vecs [10];
    logic [31:0] rd0, rd1, r32;
    int          lat0, lat1, s0, acc1;
    logic [31:0] b2b_exp [4];

    initial begin
        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; wdat = '0; sel = '0;
        for (int m = 0; m < 2; m++) begin
            head_start[m] = 0; m_acc[m] = 0;
            for (int i = 0; i < 1024; i++) m_valid[m][i] = 1'b0;
        end
        clear_logs();

        repeat (3) tick();
        check("rst_ack0", 32'(ack_o0), 32'h0);
        check("rst_ack1", 32'(ack_o1), 32'h0);
        check("rst_stall0", 32'(stall_o0), 32'h0);
        check("rst_stall1", 32'(stall_o1), 32'h0);
        check("rst_dat0", dat_o0, 32'h0);
        check("rst_dat1", dat_o1, 32'h0);
        rst = 1'b0; cyc = 1'b1;
        tick();

        // Single transactions on an empty queue: data and latency 2+LATENCY.
        vecs[0] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0};
        vecs[1] = '{1'b0, 32'h0000_0010, 32'h0,         4'hF, 32'hDEAD_BEEF};
        vecs[2] = '{1'b1, 32'h0000_0020, 32'h1122_3344, 4'hF, 32'h0};
        vecs[3] = '{1'b1, 32'h0000_0020, 32'hAABB_CCDD, 4'h5, 32'h0};
        vecs[4] = '{1'b0, 32'h0000_0020, 32'h0,         4'hF, 32'h11BB_33DD};
        vecs[5] = '{1'b1, 32'h0000_1000, 32'hCAFE_F00D, 4'hF, 32'h0};
        vecs[6] = '{1'b0, 32'h0000_0000, 32'h0,         4'hF, 32'hCAFE_F00D};
        vecs[7] = '{1'b0, 32'h0000_1010, 32'h0,         4'hF, 32'hDEAD_BEEF};
        vecs[8] = '{1'b1, 32'h0000_0040, 32'h1234_5678, 4'hF, 32'h0};
        vecs[9] = '{1'b0, 32'h0000_0043, 32'h0,         4'hF, 32'h1234_5678};
        for (int i = 0; i < 10; i++) begin
            do_op(vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].s, rd0, rd1, lat0, lat1);
            check("vec_dat0", rd0, vecs[i].exp);
            check("vec_dat1", rd1, vecs[i].exp);
            check("vec_lat0", lat0, 2 + LAT0);
            check("vec_lat1", lat1, 2 + LAT1);
            drain();
        end

        // Write then read on consecutive cycles.
        clear_logs();
        s0 = cycle_n;
        present(1'b1, 32'h80, 32'h600D_CAFE, 4'hF);
        present(1'b0, 32'h80, 32'h0, 4'hF);
        drain();
        check("pair0_n", ack_log0.size(), 2);
        check_ack("pair0", 0, 0, 32'h0, s0 + 2);
        check_ack("pair0", 0, 1, 32'h600D_CAFE, s0 + 3);
        check_ack("pair1", 1, 0, 32'h0, s0 + 5);
        check_ack("pair1", 1, 1, 32'h600D_CAFE, s0 + 9);

        // Four back-to-back reads: LATENCY=0 never stalls, acks every cycle.
        clear_logs();
        b2b_exp[0] = 32'hDEAD_BEEF; b2b_exp[1] = 32'h11BB_33DD;
        b2b_exp[2] = 32'hCAFE_F00D; b2b_exp[3] = 32'h600D_CAFE;
        s0 = cycle_n;
        present(1'b0, 32'h10, 32'h0, 4'hF);
        present(1'b0, 32'h20, 32'h0, 4'hF);
        present(1'b0, 32'h00, 32'h0, 4'hF);
        present(1'b0, 32'h80, 32'h0, 4'hF);
        drain();
        check("b2b_stall0", 32'(stall_seen0), 32'h0);
        check("b2b_n0", ack_log0.size(), 4);
        for (int i = 0; i < 4; i++) check_ack("b2b0", 0, i, b2b_exp[i], s0 + 2 + i);

        // Strobe held with LATENCY=3: stall rises, acks every 4 cycles.
        clear_logs();
        acc1 = m_acc[1];
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h10; sel = 4'hF;
        repeat (24) tick();
        drain();
        check("stream_stall1", 32'(stall_seen1), 32'h1);
        check("stream_n1", ack_log1.size(), m_acc[1] - acc1);
        check("stream_n0", ack_log0.size(), 24);
        for (int i = 1; i < ack_cyc1.size(); i++)
            check("stream_gap1", ack_cyc1[i] - ack_cyc1[i-1], 4);
        for (int i = 0; i < ack_log1.size(); i++)
            check("stream_dat1", ack_log1[i], 32'hDEAD_BEEF);

        // Abort: queued write dropped by cyc going low.
        clear_logs();
        present(1'b1, 32'h40, 32'h5555_5555, 4'hF);
        cyc = 1'b0; stb = 1'b0;
        tick();
        check("abort_ack0", 32'(ack_o0), 32'h0);
        check("abort_ack1", 32'(ack_o1), 32'h0);
        check("abort_stall0", 32'(stall_o0), 32'h0);
        check("abort_stall1", 32'(stall_o1), 32'h0);
        cyc = 1'b1;
        repeat (8) tick();
        check("abort_noack0", ack_log0.size(), 0);
        check("abort_noack1", ack_log1.size(), 0);
        do_op(1'b0, 32'h40, 32'h0, 4'hF, rd0, rd1, lat0, lat1);
        check("abort_rd0", rd0, 32'h1234_5678);
        check("abort_rd1", rd1, 32'h1234_5678);
        drain();

        // Reset with two requests pending.
        clear_logs();
        present(1'b0, 32'h10, 32'h0, 4'hF);
        present(1'b0, 32'h20, 32'h0, 4'hF);
        stb = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mrst_ack0", 32'(ack_o0), 32'h0);
        check("mrst_ack1", 32'(ack_o1), 32'h0);
        check("mrst_stall1", 32'(stall_o1), 32'h0);
        check("mrst_dat0", dat_o0, 32'h0);
        check("mrst_dat1", dat_o1, 32'h0);
        repeat (10) tick();
        check("mrst_acks0", ack_log0.size(), 1);
        check("mrst_acks1", ack_log1.size(), 0);

        // Random traffic over eight pre-written words, with aliasing.
        for (int k = 0; k < 8; k++) begin
            do_op(1'b1, 32'((32'h100 + k) << 2), $urandom(), 4'hF, rd0, rd1, lat0, lat1);
            check("pre_dat0", rd0, 32'h0);
            drain();
        end
        for (int i = 0; i < 400; i++) begin
            r32  = $urandom();
            rst  = ($urandom_range(0, 199) == 0);
            cyc  = ($urandom_range(0, 15) != 0);
            stb  = ($urandom_range(0, 9) < 7);
            we   = $urandom_range(0, 1) == 1;
            adr  = {r32[31:12], 10'(10'h100 + 10'($urandom_range(0, 7))), r32[1:0]};
            wdat = $urandom();
            sel  = 4'($urandom_range(0, 15));
            tick();
        end
        rst = 1'b0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
